spi_slave_tx: RTL

- SPI responder-side transmitter: consumes master-driven spi_bus_clk and cs_n and shifts a parallel word out on sdo.
- Sits opposite spi_tx/spi_rx. Lets a local core answer an external SPI master.
- Fully synchronous to the system clk: bus signals are oversampled and edge-detected, never used as clocks.
- Holds one word from a ready/valid upstream interface in a single-entry buffer.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_slave_tx.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder transmitter: FSM states,
// bus mode constants and the frame-length clamp.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam logic CPOL_LOW   = 1'b0;
  localparam logic CPOL_HIGH  = 1'b1;
  localparam logic CPHA_LEAD  = 1'b0;
  localparam logic CPHA_TRAIL = 1'b1;

  // A request of 0 or anything longer than the shifter means a full-width frame.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned max_len);
    int unsigned r;
    if ((len == 32'd0) || (len > max_len)) begin
      r = max_len;
    end else begin
      r = len;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus pin, plus one delay flop
// that turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;
  logic meta_d, sync_d, prev_d;

  // next values of the synchronizer chain
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // synchronizer and edge-detect flops
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI responder transmitter: oversamples the master's clock and select, shifts one
// buffered word per frame onto sdo. SPI_SLV_TX_LSB_FIRST_EN adds the lsb_first port.
module spi_slave_tx
  import spi_pkg::*;
#(
  parameter int SPI_TX_WIDTH = 8,
  parameter int CNT_W        = $clog2(SPI_TX_WIDTH + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cpol,
  input  logic                    cpoa,
  input  logic [CNT_W-1:0]        length,
`ifdef SPI_SLV_TX_LSB_FIRST_EN
  input  logic                    lsb_first,
`endif
  input  logic [SPI_TX_WIDTH-1:0] tx_data,
  input  logic                    tx_vld,
  output logic                    tx_rdy,
  input  logic                    cs_n,
  input  logic                    spi_bus_clk,
  output logic                    sdo,
  output logic                    sdo_oe,
  output logic                    tx_eot,
  output logic                    tx_underrun
);

  localparam int W = SPI_TX_WIDTH;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  spi_state_e       state_q, state_d;
  logic             cpol_q, cpol_d, cpoa_q, cpoa_d;
  logic [CNT_W-1:0] len_q, len_d, bitcnt_q, bitcnt_d;
  logic [W-1:0]     buf_q, buf_d, shreg_q, shreg_d;
  logic             buf_full_q, buf_full_d, tx_rdy_q, tx_rdy_d;
  logic             sdo_q, sdo_d, sdo_oe_q, sdo_oe_d;
  logic             tx_eot_q, tx_eot_d, tx_underrun_q, tx_underrun_d;
  logic             bclk_rise_s, bclk_fall_s, cs_rise_s, cs_fall_s;
  logic             lead_s, trail_s, shift_ev_s, sample_ev_s, accept_s, lsb_s;
  logic [CNT_W-1:0] len_eff_s, shamt_s, bitcnt_inc_s;
  logic [W-1:0]     load_s, aligned_s;

  function automatic logic head_bit(input logic [W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[W-1];
  endfunction

  function automatic logic [W-1:0] shift_out(input logic [W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[W-1:1]} : {v[W-2:0], 1'b0};
  endfunction

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_bclk (
    .clk(clk), .rstn(rstn), .din(spi_bus_clk), .rise(bclk_rise_s), .fall(bclk_fall_s)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rstn(rstn), .din(cs_n), .rise(cs_rise_s), .fall(cs_fall_s)
  );

`ifdef SPI_SLV_TX_LSB_FIRST_EN
  logic lsb_q, lsb_d;

  // bit order is frozen for the whole frame at select
  always_comb begin
    if ((state_q == IDLE) && cs_fall_s) begin
      lsb_d = lsb_first;
    end else begin
      lsb_d = lsb_q;
    end
  end

  // bit-order register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lsb_q <= 1'b0;
    end else begin
      lsb_q <= lsb_d;
    end
  end

  assign lsb_s = lsb_q;
`else
  assign lsb_s = 1'b0;
`endif

  assign lead_s       = (cpol_q == CPOL_LOW) ? bclk_rise_s : bclk_fall_s;
  assign trail_s      = (cpol_q == CPOL_LOW) ? bclk_fall_s : bclk_rise_s;
  assign shift_ev_s   = (cpoa_q == CPHA_LEAD) ? trail_s : lead_s;
  assign sample_ev_s  = (cpoa_q == CPHA_LEAD) ? lead_s : trail_s;
  assign len_eff_s    = CNT_W'(eff_len(32'(length), W));
  assign bitcnt_inc_s = bitcnt_q + CNT_ONE;
  assign accept_s     = tx_vld & tx_rdy_q;
  // MSB-first frames shorter than W are left-aligned so bit len-1 sits at the top
  assign shamt_s      = CNT_W'(W) - len_q;
  assign load_s       = buf_full_q ? buf_q : {W{1'b0}};
  assign aligned_s    = lsb_s ? load_s : (load_s << shamt_s);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = cs_fall_s ? LOAD : IDLE;
      LOAD:    state_d = cs_rise_s ? IDLE : SHIFT;
      SHIFT: begin
        if (cs_rise_s) begin
          state_d = IDLE;
        end else if (sample_ev_s && (bitcnt_inc_s == len_q)) begin
          state_d = HOLD;
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD:    state_d = cs_rise_s ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end

  // single-entry buffer: LOAD drains it, a handshake refills it
  always_comb begin
    if (state_q == LOAD) begin
      buf_full_d = 1'b0;
    end else begin
      buf_full_d = buf_full_q;
    end
    if (accept_s) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end
    tx_rdy_d = ~buf_full_d;
  end

  // output and datapath logic
  always_comb begin
    cpol_d        = cpol_q;
    cpoa_d        = cpoa_q;
    len_d         = len_q;
    shreg_d       = shreg_q;
    bitcnt_d      = bitcnt_q;
    sdo_d         = sdo_q;
    sdo_oe_d      = sdo_oe_q;
    tx_eot_d      = 1'b0;
    tx_underrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
        if (cs_fall_s) begin
          cpol_d = cpol;
          cpoa_d = cpoa;
          len_d  = len_eff_s;
        end else begin
          len_d = len_q;
        end
      end
      LOAD: begin
        bitcnt_d      = {CNT_W{1'b0}};
        tx_underrun_d = ~buf_full_q;
        if (cs_rise_s) begin
          sdo_oe_d = 1'b0;
          sdo_d    = 1'b0;
        end else if (cpoa_q == CPHA_LEAD) begin
          sdo_oe_d = 1'b1;
          sdo_d    = head_bit(aligned_s, lsb_s);
          shreg_d  = shift_out(aligned_s, lsb_s);
        end else begin
          sdo_oe_d = 1'b1;
          sdo_d    = 1'b0;
          shreg_d  = aligned_s;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          sdo_oe_d = 1'b0;
          sdo_d    = 1'b0;
        end else begin
          if (shift_ev_s) begin
            sdo_d   = head_bit(shreg_q, lsb_s);
            shreg_d = shift_out(shreg_q, lsb_s);
          end else begin
            sdo_d = sdo_q;
          end
          if (sample_ev_s) begin
            bitcnt_d = bitcnt_inc_s;
            tx_eot_d = (bitcnt_inc_s == len_q);
          end else begin
            bitcnt_d = bitcnt_q;
          end
        end
      end
      HOLD: begin
        if (cs_rise_s) begin
          sdo_oe_d = 1'b0;
          sdo_d    = 1'b0;
        end else begin
          sdo_d = sdo_q;
        end
      end
      default: begin
        sdo_d    = 1'b0;
        sdo_oe_d = 1'b0;
      end
    endcase
  end

  // datapath, buffer and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cpol_q        <= 1'b0;
      cpoa_q        <= 1'b0;
      len_q         <= {CNT_W{1'b0}};
      bitcnt_q      <= {CNT_W{1'b0}};
      buf_q         <= {W{1'b0}};
      shreg_q       <= {W{1'b0}};
      buf_full_q    <= 1'b0;
      tx_rdy_q      <= 1'b0;
      sdo_q         <= 1'b0;
      sdo_oe_q      <= 1'b0;
      tx_eot_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      cpol_q        <= cpol_d;
      cpoa_q        <= cpoa_d;
      len_q         <= len_d;
      bitcnt_q      <= bitcnt_d;
      buf_q         <= buf_d;
      shreg_q       <= shreg_d;
      buf_full_q    <= buf_full_d;
      tx_rdy_q      <= tx_rdy_d;
      sdo_q         <= sdo_d;
      sdo_oe_q      <= sdo_oe_d;
      tx_eot_q      <= tx_eot_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign tx_rdy      = tx_rdy_q;
  assign sdo         = sdo_q;
  assign sdo_oe      = sdo_oe_q;
  assign tx_eot      = tx_eot_q;
  assign tx_underrun = tx_underrun_q;

endmodule
